// File: rtl/fifo_upsize_pkg.sv
// Shared types and the halfword packing helper for the 16-to-32 upsizing FIFO.
package fifo_upsize_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef logic [HALF_W-1:0] half_t;
  typedef logic [WORD_W-1:0] word_t;

  // Older halfword lands in the upper half so a split/pack round trip is lossless.
  function automatic word_t pack_halves(half_t hi, half_t lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fifo_upsize_mem.sv
// DEPTH x 16 storage: one synchronous write port, two asynchronous read ports
// at rd_addr and rd_addr+1 (wrapping mod DEPTH).
module fifo_upsize_mem
  import fifo_upsize_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  half_t            wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output half_t            rd_data [2]
);

  half_t mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_data[gi] = mem[rd_addr + PTR_W'(gi)];
    end
  endgenerate

endmodule

// File: rtl/fifo_upsize.sv
// 16-to-32 bit packing FIFO: two halfwords in, one word out, first halfword in [31:16].
// Optional macro FIFO_UPSIZE_FLUSH_EN adds a flush input that drains a trailing odd halfword.
module fifo_upsize
  import fifo_upsize_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIFO_UPSIZE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [HALF_W-1:0] data_in,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_vld,
  input  logic              data_out_rdy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [PTR_W-1:0] pop_step;
  logic             push, pop, pair_ready, in_block, drain_odd;
  half_t            rd_data [2];

`ifdef FIFO_UPSIZE_FLUSH_EN
  logic flush_pend_reg, flush_pend_next;
`endif

  fifo_upsize_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // While flushing, input is blocked and a lone halfword is emitted zero-padded.
  always_comb begin
    in_block  = 1'b0;
    drain_odd = 1'b0;
`ifdef FIFO_UPSIZE_FLUSH_EN
    in_block  = flush_pend_reg;
    drain_odd = flush_pend_reg && (count_reg == (PTR_W+1)'(1));
`endif
  end

  assign pair_ready   = (count_reg >= (PTR_W+1)'(2));
  assign data_in_rdy  = (count_reg < DEPTH_C) && !in_block;
  assign data_out_vld = pair_ready || drain_odd;
  assign data_out     = pair_ready ? pack_halves(rd_data[0], rd_data[1]) :
                        drain_odd  ? pack_halves(rd_data[0], '0) : '0;

  assign push     = data_in_vld && data_in_rdy;
  assign pop      = data_out_vld && data_out_rdy;
  assign pop_step = drain_odd ? PTR_W'(1) : PTR_W'(2);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      count_next  = count_next + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + pop_step;
      count_next  = count_next - {1'b0, pop_step};
    end
  end

`ifdef FIFO_UPSIZE_FLUSH_EN
  always_comb begin
    flush_pend_next = flush_pend_reg;
    if (flush_pend_reg && (count_next == '0)) begin
      flush_pend_next = 1'b0;
    end else if (flush && !flush_pend_reg) begin
      flush_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_reg <= 1'b0;
    end else begin
      flush_pend_reg <= flush_pend_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_fifo_upsize.sv
// Randomized self-checking bench for fifo_upsize against a queue-based halfword model.
module tb_fifo_upsize;
  import fifo_upsize_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_in_vld = 1'b0;
  logic        data_in_rdy;
  logic [31:0] data_out;
  logic        data_out_vld;
  logic        data_out_rdy = 1'b0;
`ifdef FIFO_UPSIZE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;

  fifo_upsize #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_UPSIZE_FLUSH_EN
    .flush        (flush),
`endif
    .data_in      (data_in),
    .data_in_vld  (data_in_vld),
    .data_in_rdy  (data_in_rdy),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy)
  );

  // Reference model: halfwords held in arrival order.
  logic [15:0] mq [$];
  bit          m_pend = 1'b0;
  bit          chk_on = 1'b0;
  logic [31:0] out_log [$];
  int          m_n;
  bit          m_rdy, m_vld, m_push, m_pop;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      m_n    = mq.size();
      m_rdy  = (m_n < DEPTH) && !m_pend;
      m_vld  = (m_n >= 2) || (m_pend && m_n == 1);
      m_push = data_in_vld && m_rdy;
      m_pop  = m_vld && data_out_rdy;
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_n >= 2) void'(mq.pop_front());
      end
      if (m_push) mq.push_back(data_in);
`ifdef FIFO_UPSIZE_FLUSH_EN
      if (m_pend && mq.size() == 0) m_pend = 1'b0;
      else if (flush && !m_pend) m_pend = 1'b1;
`endif
    end
  end

  // Per-cycle comparison, mid-cycle, against the model state.
  always @(negedge clk) begin
    if (chk_on) begin
      logic        e_rdy, e_vld;
      logic [31:0] e_data;
      e_rdy  = (mq.size() < DEPTH) && !m_pend;
      e_vld  = (mq.size() >= 2) || (m_pend && mq.size() == 1);
      e_data = (mq.size() >= 2) ? {mq[0], mq[1]} :
               (e_vld ? {mq[0], 16'h0000} : 32'h0);
      check("cyc_rdy", 32'(data_in_rdy), 32'(e_rdy));
      check("cyc_vld", 32'(data_out_vld), 32'(e_vld));
      check("cyc_data", data_out, e_data);
      if (!rst && data_out_vld && data_out_rdy) begin
        out_log.push_back(data_out);
        $display("xfer word %0d: %h", out_log.size() - 1, data_out);
      end
    end
  end

  logic        obs_rdy, obs_vld, acc;
  logic [31:0] obs_data;

  // One cycle: drive just after posedge, observe at negedge, return just after next posedge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r, output logic a);
    data_in_vld  = v;
    data_in      = d;
    data_out_rdy = r;
    @(negedge clk);
    obs_rdy  = data_in_rdy;
    obs_vld  = data_out_vld;
    obs_data = data_out;
    a = v && data_in_rdy;
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (cyc_cnt > 60000) begin
      bad++;
      $display("FAIL timeout: got %0d cycles expected under 60000", cyc_cnt);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  initial begin
    logic [15:0] sent [$];
    logic [15:0] d;
    int          n_acc;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_rdy", 32'(data_in_rdy), 32'd1);
    check("reset_vld", 32'(data_out_vld), 32'd0);
    check("reset_data", data_out, 32'h0);

    // First word latency and value
    out_log.delete();
    cyc(1'b1, 16'hAAAA, 1'b1, acc);
    cyc(1'b1, 16'h5555, 1'b1, acc);
    check("t1_vld_before", 32'(obs_vld), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t1_vld_after", 32'(obs_vld), 32'd1);
    check("t1_data", obs_data, 32'hAAAA5555);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t1_one_beat", 32'(obs_vld), 32'd0);
    check("t1_log_size", 32'(out_log.size()), 32'd1);

    // Fill to full, ninth halfword refused, then drain
    out_log.delete();
    n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 16'h0100 + 16'(i), 1'b0, acc);
      if (i < 8) n_acc += int'(acc);
    end
    check("t2_accepted", 32'(n_acc), 32'd8);
    check("t2_ninth_acc", 32'(acc), 32'd0);
    check("t2_full_rdy", 32'(obs_rdy), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t2_rdy_pop_cycle", 32'(obs_rdy), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t2_rdy_reopen", 32'(obs_rdy), 32'd1);
    repeat (3) cyc(1'b0, 16'h0, 1'b1, acc);
    check("t2_log_size", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      check("t2_word0", out_log[0], 32'h01000101);
      for (int k = 1; k < 4; k++)
        check("t2_word", out_log[k], {16'h0100 + 16'(2*k), 16'h0101 + 16'(2*k)});
    end

    // Random stream across many pointer wraps
    out_log.delete();
    for (int k = 0; k < 1000; k++) begin
      d = 16'($urandom);
      do cyc(1'b1, d, 1'($urandom_range(0, 1)), acc); while (!acc);
      sent.push_back(d);
    end
    repeat (8) cyc(1'b0, 16'h0, 1'b1, acc);
    check("t3_log_size", 32'(out_log.size()), 32'd500);
    if (out_log.size() == 500) begin
      for (int k = 0; k < 500; k++)
        check("t3_word", out_log[k], {sent[2*k], sent[2*k+1]});
    end

    // Odd halfword waits for a partner
    out_log.delete();
    cyc(1'b1, 16'hC001, 1'b1, acc);
    cyc(1'b1, 16'hC002, 1'b1, acc);
    cyc(1'b1, 16'hC003, 1'b1, acc);
    repeat (20) cyc(1'b0, 16'h0, 1'b1, acc);
    check("t4_log_size", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) check("t4_word", out_log[0], 32'hC001C002);
    check("t4_vld_idle", 32'(obs_vld), 32'd0);

    // Mid-stream reset with five halfwords held
    for (int k = 0; k < 4; k++) cyc(1'b1, 16'hD001 + 16'(k), 1'b0, acc);
    data_in_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_vld", 32'(data_out_vld), 32'd0);
    check("t5_rst_rdy", 32'(data_in_rdy), 32'd1);
    check("t5_rst_data", data_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_log.delete();
    cyc(1'b1, 16'h1234, 1'b1, acc);
    cyc(1'b1, 16'h5678, 1'b1, acc);
    cyc(1'b0, 16'h0, 1'b1, acc);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t5_log_size", 32'(out_log.size()), 32'd1);
    if (out_log.size() > 0) check("t5_word", out_log[0], 32'h12345678);

`ifdef FIFO_UPSIZE_FLUSH_EN
    // Flush drains the trailing odd halfword zero-padded
    out_log.delete();
    cyc(1'b1, 16'h1111, 1'b0, acc);
    cyc(1'b1, 16'h2222, 1'b0, acc);
    cyc(1'b1, 16'h3333, 1'b0, acc);
    flush = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, acc);
    flush = 1'b0;
    cyc(1'b1, 16'hEEEE, 1'b1, acc);
    check("t6_rdy_drain0", 32'(obs_rdy), 32'd0);
    check("t6_no_accept", 32'(acc), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t6_rdy_drain1", 32'(obs_rdy), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, acc);
    check("t6_rdy_reopen", 32'(obs_rdy), 32'd1);
    check("t6_log_size", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      check("t6_word0", out_log[0], 32'h11112222);
      check("t6_word1", out_log[1], 32'h33330000);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
